hour_chime: RTL and testbench

HOUR_CHIME -- requirements
Module: hour_chime

---
 rtl/clock_pkg.sv | 33 +++
 rtl/tone_gen.sv | 44 ++++
 rtl/hour_chime.sv | 115 +++++++++++
 tb/tb_hour_chime.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared clock-domain definitions: chime state encoding, BCD hour limits and
// the hour-to-strike conversion used by the hourly chime.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } chime_state_e;

  localparam logic [3:0] BCD_HH_TENS_MAX = 4'd2;
  localparam logic [3:0] BCD_UNITS_MAX   = 4'd9;
  localparam int         HOUR_MAX        = 23;
  localparam int         STRIKE_MODULUS  = 12;

  function automatic logic bcd_hour_valid(input logic [7:0] hh);
    int h;
    h = 10 * int'(hh[7:4]) + int'(hh[3:0]);
    return (hh[7:4] <= BCD_HH_TENS_MAX) && (hh[3:0] <= BCD_UNITS_MAX) &&
           (h <= HOUR_MAX);
  endfunction

  // Midnight and noon strike twelve, not zero.
  function automatic logic [3:0] hour_to_strikes(input logic [7:0] hh);
    int h;
    int s;
    h = 10 * int'(hh[7:4]) + int'(hh[3:0]);
    s = h % STRIKE_MODULUS;
    if (s == 0) s = STRIKE_MODULUS;
    return 4'(s);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Buzzer square-wave divider; output is high on the first enabled cycle and
// toggles every HALF cycles, restarting from the high phase on each enable.
module tone_gen #(
  parameter int HALF = 6000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tone_o
);

  localparam int            CW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= RELOAD;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = RELOAD;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = RELOAD;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign tone_o = en_i & phase_q;

endmodule

// File: rtl/hour_chime.sv
// Hourly chime sequencer: on the hour strobe, beeps h mod 12 times (12 for
// zero) with fixed on/off windows, reporting busy and a done pulse.
//
// state | meaning
// IDLE  | waiting for an on-the-hour strobe
// ON    | beep window, tone running
// OFF   | silent gap between beeps
module hour_chime
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int TONE_HALF = 6000,
  parameter int ON_CYC    = 2_400_000,
  parameter int OFF_CYC   = 3_600_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flag,
  input  logic [23:0] time_in,
  output logic        beep,
  output logic        busy,
  output logic        done
);

  localparam int DUR_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX + 1) : 1;
  localparam logic [DUR_W-1:0] ON_LOAD  = DUR_W'(ON_CYC - 1);
  localparam logic [DUR_W-1:0] OFF_LOAD = DUR_W'(OFF_CYC - 1);

  chime_state_e     state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [3:0]       strike_q, strike_d;
  logic             done_q, done_d;
  logic [7:0]       hh;

  logic unused_inputs;
  assign unused_inputs = ^time_in[15:0] ^ (CLK_HZ > 0);

  assign hh = time_in[23:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dur_q    <= '0;
      strike_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dur_q    <= dur_d;
      strike_q <= strike_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    strike_d = strike_q;
    done_d   = 1'b0;
    if (!en) begin
      state_d  = ST_IDLE;
      dur_d    = '0;
      strike_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (flag && bcd_hour_valid(hh)) begin
            strike_d = hour_to_strikes(hh);
            dur_d    = ON_LOAD;
            state_d  = ST_ON;
          end
        end
        ST_ON: begin
          if (dur_q == '0) begin
            strike_d = strike_q - 4'd1;
            if (strike_q == 4'd1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_OFF;
              dur_d   = OFF_LOAD;
            end
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
        ST_OFF: begin
          if (dur_q == '0) begin
            state_d = ST_ON;
            dur_d   = ON_LOAD;
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  tone_gen #(
    .HALF(TONE_HALF)
  ) u_tone (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_ON),
    .tone_o(beep)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_hour_chime.sv
// Randomized bench for hour_chime: a timeline model of expected busy/beep/done
// per cycle plus a queue of expected done cycles, checked by a separate monitor.
module tb_hour_chime;

  localparam int TH   = 2;
  localparam int ONC  = 10;
  localparam int OFFC = 15;
  localparam int MAXC = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        flag = 1'b0;
  logic [23:0] time_in = '0;
  logic        beep, busy, done;

  hour_chime #(
    .CLK_HZ   (12_000_000),
    .TONE_HALF(TH),
    .ON_CYC   (ONC),
    .OFF_CYC  (OFFC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .flag   (flag),
    .time_in(time_in),
    .beep   (beep),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected {busy, beep, done} for every cycle index
  logic [2:0] exp_tr [MAXC];
  int dq[$];
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int mon_d;

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      total++;
      if ({busy, beep, done} !== exp_tr[cyc]) begin
        bad++;
        $display("FAIL trace cyc=%0d busy/beep/done got=%b want=%b",
                 cyc, {busy, beep, done}, exp_tr[cyc]);
      end
      if (done === 1'b1) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected cyc=%0d got=1 want=no pending done", cyc);
        end else begin
          mon_d = dq.pop_front();
          if (mon_d != cyc) begin
            bad++;
            $display("FAIL done_cycle got=%0d want=%0d", cyc, mon_d);
          end
        end
      end
    end
  end

  function automatic int ref_strikes(input logic [7:0] hh);
    int t, u, h;
    t = int'(hh[7:4]);
    u = int'(hh[3:0]);
    if (t > 2 || u > 9) return 0;
    h = 10 * t + u;
    if (h > 23) return 0;
    if (h % 12 == 0) return 12;
    return h % 12;
  endfunction

  task automatic set_exp(input int idx, input logic [2:0] v);
    if (idx >= 0 && idx < MAXC) exp_tr[idx] = v;
  endtask

  // Sequence accepted on a flag seen during cycle c with n strikes.
  task automatic schedule(input int c, input int n);
    int base, d;
    for (int k = 0; k < n; k++) begin
      base = c + 1 + k * (ONC + OFFC);
      for (int j = 0; j < ONC; j++)
        set_exp(base + j, {1'b1, ((j / TH) % 2 == 0), 1'b0});
      if (k < n - 1)
        for (int j = 0; j < OFFC; j++) set_exp(base + ONC + j, 3'b100);
    end
    d = c + 1 + n * ONC + (n - 1) * OFFC;
    set_exp(d, 3'b001);
    dq.push_back(d);
  endtask

  // en low or rst high during cycle a: idle and silent from a+1 onward.
  task automatic abort(input int a);
    for (int i = a + 1; i < a + 400 && i < MAXC; i++) exp_tr[i] = 3'b000;
    if (dq.size() > 0 && dq[$] > a) void'(dq.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flag(input logic [7:0] hh);
    int n;
    time_in = {hh, 16'($urandom)};
    flag = 1'b1;
    n = ref_strikes(hh);
    if (en && !rst && !exp_tr[cyc][2] && n > 0) schedule(cyc, n);
    tick();
    flag = 1'b0;
  endtask

  task automatic drop_en();
    en = 1'b0;
    abort(cyc);
    time_in = {8'h05, 16'h0000};
    flag = 1'b1;
    tick();
    flag = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    abort(cyc);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_idle(input bit rand_flags);
    int guard;
    guard = 0;
    while (cyc < MAXC - 1 && exp_tr[cyc][2]) begin
      if (rand_flags && $urandom_range(0, 39) == 0) pulse_flag(8'($urandom_range(0, 35)));
      else tick();
      guard++;
      if (guard > 1000) begin
        total++;
        bad++;
        $display("FAIL wait_idle timeout cyc=%0d got=busy want=idle", cyc);
        break;
      end
    end
  endtask

  function automatic logic [7:0] rand_hour();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
  endfunction

  int c0;

  initial begin
    for (int i = 0; i < MAXC; i++) exp_tr[i] = 3'b000;
    rst = 1'b1;
    en = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // basic strike counts
    pulse_flag(8'h03); wait_idle(0); tick(); tick();
    pulse_flag(8'h00); wait_idle(0); tick();
    pulse_flag(8'h12); wait_idle(0); tick();
    pulse_flag(8'h13); wait_idle(0); tick();

    // invalid hours
    pulse_flag(8'h24); tick(); tick(); tick();
    pulse_flag(8'h1A); tick(); tick(); tick();

    // flag in the done cycle is accepted; second flag mid strike 2 is ignored
    c0 = cyc;
    pulse_flag(8'h01);
    run_until(c0 + 1 + ONC);
    c0 = cyc;
    pulse_flag(8'h02);
    run_until(c0 + 1 + ONC + OFFC + 2);
    pulse_flag(8'h05);
    wait_idle(0); tick();

    // en dropped mid-OFF
    c0 = cyc;
    pulse_flag(8'h03);
    run_until(c0 + 1 + ONC + 7);
    drop_en();
    tick(); tick();

    // reset mid-ON
    c0 = cyc;
    pulse_flag(8'h04);
    run_until(c0 + 1 + ONC + OFFC + 4);
    rst_pulse();
    tick(); tick();

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      int r, g;
      g = $urandom_range(0, 4);
      for (int k = 0; k < g; k++) tick();
      pulse_flag(rand_hour());
      r = $urandom_range(0, 9);
      if (r == 0) begin
        g = $urandom_range(1, 150);
        for (int k = 0; k < g; k++) tick();
        drop_en();
      end else if (r == 1) begin
        g = $urandom_range(1, 150);
        for (int k = 0; k < g; k++) tick();
        rst_pulse();
      end
      wait_idle(1);
    end

    tick(); tick(); tick();
    chk_en = 1'b0;
    total++;
    if (dq.size() != 0) begin
      bad++;
      $display("FAIL done_missing pending=%0d want=0", dq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
